// File: rtl/rtc_timebase_if.sv
// Control, load, calendar and strobe signals of the RTC timebase.
// Alarm signals exist only when RTC_ALARM_EN is defined.
interface rtc_timebase_if #(
  parameter int unsigned DAY_W = 5
);
  logic             run;
  logic             load;
  logic [9:0]       ld_ms;
  logic [5:0]       ld_sec;
  logic [5:0]       ld_min;
  logic [4:0]       ld_hour;
  logic [DAY_W-1:0] ld_day;
  logic [9:0]       millisec;
  logic [5:0]       sec;
  logic [5:0]       min;
  logic [4:0]       hour;
  logic [DAY_W-1:0] day;
  logic             ms_tick;
  logic             sec_tick;
  logic             day_wrap;
`ifdef RTC_ALARM_EN
  logic [5:0]       alm_sec;
  logic [5:0]       alm_min;
  logic [4:0]       alm_hour;
  logic             alm_ack;
  logic             alarm_irq;
`endif

  modport master (
    output run, load, ld_ms, ld_sec, ld_min, ld_hour, ld_day,
    input  millisec, sec, min, hour, day, ms_tick, sec_tick, day_wrap
`ifdef RTC_ALARM_EN
    , output alm_sec, alm_min, alm_hour, alm_ack,
    input  alarm_irq
`endif
  );

  modport slave (
    input  run, load, ld_ms, ld_sec, ld_min, ld_hour, ld_day,
    output millisec, sec, min, hour, day, ms_tick, sec_tick, day_wrap
`ifdef RTC_ALARM_EN
    , input alm_sec, alm_min, alm_hour, alm_ack,
    output alarm_irq
`endif
  );
endinterface

// File: rtl/rtc_timebase.sv
// Millisecond prescaler plus ms/sec/min/hour/day calendar with run/pause, load and strobes.
// Optional sticky alarm compare enabled by defining RTC_ALARM_EN.
module rtc_timebase #(
  parameter int unsigned CLK_PER_MS = 10,
  parameter int unsigned DAY_MAX    = 30,
  parameter int unsigned DAY_W      = 5
) (
  input logic           clk,
  input logic           reset,
  rtc_timebase_if.slave bus_io
);
  localparam int unsigned      PreW    = (CLK_PER_MS > 1) ? $clog2(CLK_PER_MS) : 1;
  localparam logic [PreW-1:0]  PreLast = PreW'(CLK_PER_MS - 1);
  localparam logic [DAY_W-1:0] DayLast = DAY_W'(DAY_MAX);

  logic [PreW-1:0]  pre_q, pre_d;
  logic [9:0]       ms_q, ms_d;
  logic [5:0]       sec_q, sec_d;
  logic [5:0]       min_q, min_d;
  logic [4:0]       hour_q, hour_d;
  logic [DAY_W-1:0] day_q, day_d;
  logic             ms_tick_q, ms_tick_d;
  logic             sec_tick_q, sec_tick_d;
  logic             day_wrap_q, day_wrap_d;

  always_comb begin
    pre_d      = pre_q;
    ms_d       = ms_q;
    sec_d      = sec_q;
    min_d      = min_q;
    hour_d     = hour_q;
    day_d      = day_q;
    ms_tick_d  = 1'b0;
    sec_tick_d = 1'b0;
    day_wrap_d = 1'b0;
    if (bus_io.load) begin
      // Each out-of-range field independently falls back to zero.
      pre_d  = '0;
      ms_d   = (bus_io.ld_ms > 10'd999)  ? '0 : bus_io.ld_ms;
      sec_d  = (bus_io.ld_sec > 6'd59)   ? '0 : bus_io.ld_sec;
      min_d  = (bus_io.ld_min > 6'd59)   ? '0 : bus_io.ld_min;
      hour_d = (bus_io.ld_hour > 5'd23)  ? '0 : bus_io.ld_hour;
      day_d  = (bus_io.ld_day > DayLast) ? '0 : bus_io.ld_day;
    end else if (bus_io.run) begin
      if (pre_q == PreLast) begin
        pre_d     = '0;
        ms_tick_d = 1'b1;
        if (ms_q == 10'd999) begin
          ms_d       = '0;
          sec_tick_d = 1'b1;
          if (sec_q == 6'd59) begin
            sec_d = '0;
            if (min_q == 6'd59) begin
              min_d = '0;
              if (hour_q == 5'd23) begin
                hour_d = '0;
                if (day_q == DayLast) begin
                  day_d      = '0;
                  day_wrap_d = 1'b1;
                end else begin
                  day_d = day_q + DAY_W'(1);
                end
              end else begin
                hour_d = hour_q + 5'd1;
              end
            end else begin
              min_d = min_q + 6'd1;
            end
          end else begin
            sec_d = sec_q + 6'd1;
          end
        end else begin
          ms_d = ms_q + 10'd1;
        end
      end else begin
        pre_d = pre_q + PreW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_q      <= '0;
      ms_q       <= '0;
      sec_q      <= '0;
      min_q      <= '0;
      hour_q     <= '0;
      day_q      <= '0;
      ms_tick_q  <= 1'b0;
      sec_tick_q <= 1'b0;
      day_wrap_q <= 1'b0;
    end else begin
      pre_q      <= pre_d;
      ms_q       <= ms_d;
      sec_q      <= sec_d;
      min_q      <= min_d;
      hour_q     <= hour_d;
      day_q      <= day_d;
      ms_tick_q  <= ms_tick_d;
      sec_tick_q <= sec_tick_d;
      day_wrap_q <= day_wrap_d;
    end
  end

  assign bus_io.millisec = ms_q;
  assign bus_io.sec      = sec_q;
  assign bus_io.min      = min_q;
  assign bus_io.hour     = hour_q;
  assign bus_io.day      = day_q;
  assign bus_io.ms_tick  = ms_tick_q;
  assign bus_io.sec_tick = sec_tick_q;
  assign bus_io.day_wrap = day_wrap_q;

`ifdef RTC_ALARM_EN
  logic irq_q, irq_d, alm_hit;

  // ms_tick_d is only high on a genuine advance, so a load can never raise the alarm.
  always_comb begin
    alm_hit = ms_tick_d && (ms_d == 10'd0) && (sec_d == bus_io.alm_sec) &&
              (min_d == bus_io.alm_min) && (hour_d == bus_io.alm_hour);
    irq_d   = irq_q;
    if (alm_hit) begin
      irq_d = 1'b1;
    end else if (bus_io.alm_ack) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign bus_io.alarm_irq = irq_q;
`endif
endmodule

// File: tb/tb_rtc_timebase.sv
// Scoreboarded bench for rtc_timebase (CLK_PER_MS=4); alarm scenario runs when RTC_ALARM_EN is set.
module tb_rtc_timebase;
  localparam int unsigned CLK_PER_MS = 4;
  localparam int unsigned DAY_MAX    = 30;
  localparam int unsigned DAY_W      = 5;

  typedef struct packed {
    logic [9:0]       ms;
    logic [5:0]       sec;
    logic [5:0]       min;
    logic [4:0]       hour;
    logic [DAY_W-1:0] day;
    logic             mt;
    logic             st;
    logic             dw;
    logic             irq;
  } snap_t;

  logic clk = 1'b0;
  logic reset;

  rtc_timebase_if #(.DAY_W(DAY_W)) bus ();

  rtc_timebase #(
    .CLK_PER_MS(CLK_PER_MS),
    .DAY_MAX   (DAY_MAX),
    .DAY_W     (DAY_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus_io(bus)
  );

  always #5 clk = ~clk;

  int    n_tests = 0;
  int    n_fail  = 0;
  snap_t exp_q[$];
  string tag_q[$];
  snap_t got, want;
  string tag;

  function automatic snap_t mk(int ms, int sec, int min, int hour, int day,
                               bit mt = 1'b0, bit st = 1'b0, bit dw = 1'b0, bit irq = 1'b0);
    snap_t s;
    s.ms   = 10'(ms);
    s.sec  = 6'(sec);
    s.min  = 6'(min);
    s.hour = 5'(hour);
    s.day  = DAY_W'(day);
    s.mt   = mt;
    s.st   = st;
    s.dw   = dw;
    s.irq  = irq;
    return s;
  endfunction

  function automatic snap_t observe();
    snap_t s;
    s.ms   = bus.millisec;
    s.sec  = bus.sec;
    s.min  = bus.min;
    s.hour = bus.hour;
    s.day  = bus.day;
    s.mt   = bus.ms_tick;
    s.st   = bus.sec_tick;
    s.dw   = bus.day_wrap;
`ifdef RTC_ALARM_EN
    s.irq  = bus.alarm_irq;
`else
    s.irq  = 1'b0;
`endif
    return s;
  endfunction

  function automatic string fmt(snap_t s);
    return $sformatf("d%0d %0d:%0d:%0d.%0d mt=%0b st=%0b dw=%0b irq=%0b",
                     s.day, s.hour, s.min, s.sec, s.ms, s.mt, s.st, s.dw, s.irq);
  endfunction

  task automatic set_in(bit run, bit load, int ms, int sec, int min, int hour, int day);
    bus.run     = run;
    bus.load    = load;
    bus.ld_ms   = 10'(ms);
    bus.ld_sec  = 6'(sec);
    bus.ld_min  = 6'(min);
    bus.ld_hour = 5'(hour);
    bus.ld_day  = DAY_W'(day);
  endtask

  task automatic push(snap_t e, string t);
    exp_q.push_back(e);
    tag_q.push_back(t);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      set_in(1'b1, 1'b1, 7, 7, 7, 7, 7);
      push(mk(0, 0, 0, 0, 0), $sformatf("reset_hold%0d", k));
      step();
      got = observe(); want = exp_q.pop_front(); tag = tag_q.pop_front(); n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL %s: got %s, required %s", tag, fmt(got), fmt(want));
      end
    end
    set_in(1'b0, 1'b0, 0, 0, 0, 0, 0);
    reset = 1'b0;
  endtask

  task automatic test_reset_midcount();
    for (int k = 0; k < 6; k++) begin
      if (k == 0) set_in(1'b0, 1'b1, 500, 0, 0, 0, 0);
      else if (k < 5) set_in(1'b1, 1'b0, 0, 0, 0, 0, 0);
      else set_in(1'b0, 1'b0, 0, 0, 0, 0, 0);
      if (k == 3) reset = 1'b1;
      push((k < 3) ? mk(500, 0, 0, 0, 0) : mk(0, 0, 0, 0, 0), $sformatf("reset_mid%0d", k));
      step();
      got = observe(); want = exp_q.pop_front(); tag = tag_q.pop_front(); n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL %s: got %s, required %s", tag, fmt(got), fmt(want));
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_prescale();
    set_in(1'b1, 1'b0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 12; k++) begin
      push(mk(k / 4, 0, 0, 0, 0, (k % 4) == 0), $sformatf("prescale%0d", k));
      step();
      got = observe(); want = exp_q.pop_front(); tag = tag_q.pop_front(); n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL %s: got %s, required %s", tag, fmt(got), fmt(want));
      end
    end
    set_in(1'b0, 1'b0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_sec_carry();
    for (int k = 0; k < 6; k++) begin
      if (k == 0) set_in(1'b0, 1'b1, 999, 59, 0, 0, 0);
      else set_in(1'b1, 1'b0, 0, 0, 0, 0, 0);
      if (k < 4) push(mk(999, 59, 0, 0, 0), $sformatf("sec_carry%0d", k));
      else if (k == 4) push(mk(0, 0, 1, 0, 0, 1'b1, 1'b1), "sec_carry_adv");
      else push(mk(0, 0, 1, 0, 0), "sec_carry_after");
      step();
      got = observe(); want = exp_q.pop_front(); tag = tag_q.pop_front(); n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL %s: got %s, required %s", tag, fmt(got), fmt(want));
      end
    end
    set_in(1'b0, 1'b0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_day_wrap();
    for (int k = 0; k < 6; k++) begin
      if (k == 0) set_in(1'b0, 1'b1, 999, 59, 59, 23, DAY_MAX);
      else set_in(1'b1, 1'b0, 0, 0, 0, 0, 0);
      if (k < 4) push(mk(999, 59, 59, 23, DAY_MAX), $sformatf("day_wrap%0d", k));
      else if (k == 4) push(mk(0, 0, 0, 0, 0, 1'b1, 1'b1, 1'b1), "day_wrap_adv");
      else push(mk(0, 0, 0, 0, 0), "day_wrap_after");
      step();
      got = observe(); want = exp_q.pop_front(); tag = tag_q.pop_front(); n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL %s: got %s, required %s", tag, fmt(got), fmt(want));
      end
    end
    set_in(1'b0, 1'b0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_load_range();
    for (int k = 0; k < 12; k++) begin
      case (k)
        0:       begin set_in(1'b0, 1'b1, 5, 63, 12, 3, 2);     push(mk(5, 0, 12, 3, 2), "ld_sec63"); end
        1:       begin set_in(1'b0, 1'b1, 1000, 59, 60, 24, 31); push(mk(0, 59, 0, 0, 0), "ld_oor"); end
        2:       begin set_in(1'b0, 1'b1, 999, 0, 59, 23, 30);  push(mk(999, 0, 59, 23, 30), "ld_max"); end
        3:       begin set_in(1'b0, 1'b1, 10, 1, 2, 3, 4);      push(mk(10, 1, 2, 3, 4), "ld_base"); end
        4, 5, 6: begin set_in(1'b1, 1'b0, 0, 0, 0, 0, 0);       push(mk(10, 1, 2, 3, 4), "ld_run"); end
        7:       begin set_in(1'b1, 1'b1, 100, 20, 21, 22, 25);
                       push(mk(100, 20, 21, 22, 25), "ld_vs_adv"); end
        11:      begin set_in(1'b1, 1'b0, 0, 0, 0, 0, 0);
                       push(mk(101, 20, 21, 22, 25, 1'b1), "ld_pre_clr_adv"); end
        default: begin set_in(1'b1, 1'b0, 0, 0, 0, 0, 0);
                       push(mk(100, 20, 21, 22, 25), $sformatf("ld_hold%0d", k)); end
      endcase
      step();
      got = observe(); want = exp_q.pop_front(); tag = tag_q.pop_front(); n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL %s: got %s, required %s", tag, fmt(got), fmt(want));
      end
    end
    set_in(1'b0, 1'b0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_pause();
    for (int k = 0; k < 10; k++) begin
      if (k == 0) set_in(1'b0, 1'b1, 50, 0, 0, 0, 0);
      else set_in((k < 3) || (k > 7), 1'b0, 0, 0, 0, 0, 0);
      if (k < 9) push(mk(50, 0, 0, 0, 0), $sformatf("pause%0d", k));
      else push(mk(51, 0, 0, 0, 0, 1'b1), "pause_resume_adv");
      step();
      got = observe(); want = exp_q.pop_front(); tag = tag_q.pop_front(); n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL %s: got %s, required %s", tag, fmt(got), fmt(want));
      end
    end
    set_in(1'b0, 1'b0, 0, 0, 0, 0, 0);
  endtask

`ifdef RTC_ALARM_EN
  task automatic test_alarm();
    bus.alm_sec  = 6'd2;
    bus.alm_min  = 6'd0;
    bus.alm_hour = 5'd0;
    for (int k = 0; k < 20; k++) begin
      bus.alm_ack = (k == 12) || (k == 18);
      case (k)
        0:           begin set_in(1'b0, 1'b1, 998, 1, 0, 0, 0); push(mk(998, 1, 0, 0, 0), "alm_ld"); end
        1, 2, 3:     begin set_in(1'b1, 1'b0, 0, 0, 0, 0, 0); push(mk(998, 1, 0, 0, 0), "alm_r0"); end
        4:           begin set_in(1'b1, 1'b0, 0, 0, 0, 0, 0);
                           push(mk(999, 1, 0, 0, 0, 1'b1), "alm_adv1"); end
        5, 6, 7:     begin set_in(1'b1, 1'b0, 0, 0, 0, 0, 0); push(mk(999, 1, 0, 0, 0), "alm_r1"); end
        8:           begin set_in(1'b1, 1'b0, 0, 0, 0, 0, 0);
                           push(mk(0, 2, 0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b1), "alm_set"); end
        9, 10, 11:   begin set_in(1'b0, 1'b0, 0, 0, 0, 0, 0);
                           push(mk(0, 2, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1), "alm_frozen"); end
        12:          begin set_in(1'b0, 1'b0, 0, 0, 0, 0, 0); push(mk(0, 2, 0, 0, 0), "alm_ack"); end
        13:          begin set_in(1'b0, 1'b1, 0, 2, 0, 0, 0); push(mk(0, 2, 0, 0, 0), "alm_ld_nomatch"); end
        14:          begin set_in(1'b0, 1'b1, 999, 1, 0, 0, 0); push(mk(999, 1, 0, 0, 0), "alm_ld2"); end
        15, 16, 17:  begin set_in(1'b1, 1'b0, 0, 0, 0, 0, 0); push(mk(999, 1, 0, 0, 0), "alm_r2"); end
        18:          begin set_in(1'b1, 1'b0, 0, 0, 0, 0, 0);
                           push(mk(0, 2, 0, 0, 0, 1'b1, 1'b1, 1'b0, 1'b1), "alm_set_vs_ack"); end
        default:     begin set_in(1'b0, 1'b0, 0, 0, 0, 0, 0);
                           push(mk(0, 2, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1), "alm_sticky"); end
      endcase
      step();
      got = observe(); want = exp_q.pop_front(); tag = tag_q.pop_front(); n_tests++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL %s: got %s, required %s", tag, fmt(got), fmt(want));
      end
    end
    bus.alm_ack = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b1;
    set_in(1'b0, 1'b0, 0, 0, 0, 0, 0);
`ifdef RTC_ALARM_EN
    // Alarm time chosen so the earlier scenarios never reach it.
    bus.alm_sec  = 6'd5;
    bus.alm_min  = 6'd5;
    bus.alm_hour = 5'd5;
    bus.alm_ack  = 1'b0;
`endif
    test_reset();
    test_reset_midcount();
    test_prescale();
    test_sec_carry();
    test_day_wrap();
    test_load_range();
    test_pause();
`ifdef RTC_ALARM_EN
    test_alarm();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
